mc_seq_ctrl: RTL and testbench

MC_SEQ_CTRL -- requirements
Module: mc_seq_ctrl

---
 rtl/mc_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mc_seq_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multicycle MIPS-style control sequencer (Moore FSM, 13 states).
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes; otherwise they execute as NOPs.
module mc_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, REX = 4'd6, RWB = 4'd7, IEX = 4'd8, IWB = 4'd9,
        BEQ = 4'd10, JMP = 4'd11, TRAP = 4'd12
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
        OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
        OP_ORI = 6'b001101, OP_BEQ = 6'b000100, OP_J = 6'b000010;
    state_t st, nxt;
    logic is_imm, legal;
    assign is_imm = op == OP_ADDI || op == OP_SLTI || op == OP_ANDI || op == OP_ORI;
    assign legal = is_imm || op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J;
    assign state = st;
    assign illegal = TRAP_EN && st == TRAP;
    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: nxt = op == OP_R ? REX : (op == OP_LW || op == OP_SW) ? MEMADR :
                          is_imm ? IEX : op == OP_BEQ ? BEQ : op == OP_J ? JMP :
                          TRAP_EN ? TRAP : FETCH;
            MEMADR: nxt = op == OP_LW ? MEMRD : MEMWR;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            REX:    nxt = RWB;
            IEX:    nxt = IWB;
            TRAP:   nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= FETCH;
        else st <= nxt;
    end
    // Control word is decoded from the state register; reset masks every side-effecting strobe.
    always_comb begin
        {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write} = '0;
        {alu_src_a, alu_src_b, alu_op, pc_src, instr_done} = '0;
        case (st)
            FETCH: begin
                mem_read = 1'b1;
                alu_src_b = 2'b01;
                alu_op = 3'b011;
                pc_write = mem_ready;
                ir_write = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op = 3'b011;
                instr_done = !legal && !TRAP_EN;
            end
            MEMADR: {alu_src_a, alu_src_b, alu_op} = {1'b1, 2'b10, 3'b011};
            MEMRD:  {mem_read, i_or_d} = 2'b11;
            MEMWB:  {reg_write, mem_to_reg, instr_done} = 3'b111;
            MEMWR: begin
                {mem_write, i_or_d} = 2'b11;
                instr_done = mem_ready;
            end
            REX:    {alu_src_a, alu_op} = {1'b1, 3'b010};
            RWB:    {reg_write, reg_dst, instr_done} = 3'b111;
            IEX: begin
                {alu_src_a, alu_src_b} = {1'b1, 2'b10};
                alu_op = op == OP_SLTI ? 3'b100 : op == OP_ANDI ? 3'b101 : op == OP_ORI ? 3'b110 : 3'b011;
            end
            IWB:    {reg_write, instr_done} = 2'b11;
            BEQ: begin
                {alu_src_a, alu_op, pc_src, instr_done} = {1'b1, 3'b001, 2'b01, 1'b1};
                pc_write = zero;
            end
            JMP:    {pc_src, pc_write, instr_done} = {2'b10, 1'b1, 1'b1};
            default: ;
        endcase
        if (!rst_n) {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done} = '0;
    end
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: directed and random instruction streams checked against a per-instruction trace model.
// Expectations for unsupported opcodes follow ILLEGAL_TRAP_EN.
module tb_mc_seq_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = '0;
    logic pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
    logic alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    int checks = 0, errors = 0;
    logic [15:0] ctl [13];
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    mc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Field order: pc_write ir_write i_or_d mem_read mem_write mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_src
    function automatic logic [15:0] obs();
        return {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src};
    endfunction

    function automatic logic [2:0] imm_aop(input logic [5:0] o);
        return o == 6'b001010 ? 3'd4 : o == 6'b001100 ? 3'd5 : o == 6'b001101 ? 3'd6 : 3'd3;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_strobes", {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Build the expected state trace of one instruction, then step it cycle by cycle.
    task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input logic z);
        int seq[$];
        bit rdy[$];
        int base, lat;
        bit trapped;
        logic [15:0] e;
        trapped = 0;
        lat = 0;
        for (int i = 0; i < fw; i++) begin seq.push_back(0); rdy.push_back(0); end
        seq.push_back(0); rdy.push_back(1);
        seq.push_back(1); rdy.push_back($urandom_range(0, 1));
        case (o)
            6'b000000: begin base = 4; seq.push_back(6); seq.push_back(7); end
            6'b100011, 6'b101011: begin
                base = o == 6'b100011 ? 5 : 4;
                seq.push_back(2); rdy.push_back($urandom_range(0, 1));
                for (int i = 0; i < mw; i++) begin seq.push_back(o == 6'b100011 ? 3 : 5); rdy.push_back(0); end
                seq.push_back(o == 6'b100011 ? 3 : 5); rdy.push_back(1);
                if (o == 6'b100011) seq.push_back(4);
            end
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin base = 4; seq.push_back(8); seq.push_back(9); end
            6'b000100: begin base = 3; seq.push_back(10); end
            6'b000010: begin base = 3; seq.push_back(11); end
            default: begin
                base = 2;
                if (TRAP) begin trapped = 1; repeat (4) seq.push_back(12); end
            end
        endcase
        while (rdy.size() < seq.size()) rdy.push_back($urandom_range(0, 1));
        if (!(o == 6'b100011 || o == 6'b101011)) base += 0;
        op = o;
        zero = z;
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            e = ctl[seq[i]];
            if (seq[i] == 0) e[15:14] = {2{rdy[i]}};
            if (seq[i] == 8) e[4:2] = imm_aop(o);
            if (seq[i] == 10) e[15] = z;
            chk("state", state, seq[i]);
            chk("ctrl", obs(), e);
            chk("done", instr_done, i == seq.size() - 1 && seq[i] != 12);
            chk("illegal", illegal, seq[i] == 12);
            if (instr_done && lat == 0) lat = i + 1;
            @(posedge clk);
            #1;
        end
        if (trapped) do_reset();
        else chk("latency", lat, base + fw + (o == 6'b100011 || o == 6'b101011 ? mw : 0));
    endtask

    initial begin
        ctl[0]  = 16'b0_0_0_1_0_0_0_0_0_01_011_00;
        ctl[1]  = 16'b0_0_0_0_0_0_0_0_0_11_011_00;
        ctl[2]  = 16'b0_0_0_0_0_0_0_0_1_10_011_00;
        ctl[3]  = 16'b0_0_1_1_0_0_0_0_0_00_000_00;
        ctl[4]  = 16'b0_0_0_0_0_1_0_1_0_00_000_00;
        ctl[5]  = 16'b0_0_1_0_1_0_0_0_0_00_000_00;
        ctl[6]  = 16'b0_0_0_0_0_0_0_0_1_00_010_00;
        ctl[7]  = 16'b0_0_0_0_0_0_1_1_0_00_000_00;
        ctl[8]  = 16'b0_0_0_0_0_0_0_0_1_10_000_00;
        ctl[9]  = 16'b0_0_0_0_0_0_0_1_0_00_000_00;
        ctl[10] = 16'b0_0_0_0_0_0_0_0_1_00_001_01;
        ctl[11] = 16'b1_0_0_0_0_0_0_0_0_00_000_10;
        ctl[12] = 16'b0;
        repeat (2) @(posedge clk);
        do_reset();
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 0, 2, 0);
        run_instr(6'b000100, 0, 0, 1);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b001101, 0, 0, 0);
        run_instr(6'b001010, 1, 0, 0);
        run_instr(6'b101011, 0, 1, 0);
        run_instr(6'b000010, 0, 0, 1);
        // Reset asserted mid-wait in MEMWR must drop the write immediately.
        op = 6'b101011;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        chk("memwr_state", state, 5);
        chk("memwr_write", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_write", mem_write, 0);
        chk("abort_state", state, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(6'b111111, 0, 0, 0);
        run_instr(6'b000000, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            logic [5:0] ops [12];
            ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001010, 6'b001100,
                    6'b001101, 6'b000100, 6'b000010, 6'b111111, 6'b000001, 6'b010000};
            run_instr(ops[$urandom_range(0, 11)], $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
